usb_cmd_decoder: RTL and testbench

- Sits directly downstream of the FT2232 FIFO interface. It reads host bytes from the IN FIFO (host-to-FPGA) and writes response bytes to the OUT FIFO (FPGA-to-host).
- Parses framed commands: echo, register write, register read. Owns a small 8-bit register file exported as a flat bus.
- One NAK response for every malformed frame.
- Runs in the application clock domain. The IN/OUT FIFOs provide the crossing.

---
 rtl/usb_cmd_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_usb_cmd_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_decoder.sv
`timescale 1ns/1ps
// usb_cmd_decoder
// Framed command parser placed behind the FT2232 FIFO bridge. It reads host
// bytes from the IN FIFO, decodes echo / register write / register read
// requests and writes response frames into the OUT FIFO. Malformed frames
// get exactly one NAK response. Owns an 8-bit register file exported flat.
//
// Request : A5 CMD LEN payload[LEN] CHK   (CHK = XOR of CMD, LEN, payload)
// Response: 5A RCMD RLEN payload[RLEN] RCHK
//
// Ports:
//   clk_i               application clock, rising edge
//   reset_i             synchronous active-high reset
//   rd_in_fifo_en_o     IN FIFO read strobe (data valid the next cycle)
//   rd_in_fifo_data_i   IN FIFO read data
//   rd_in_fifo_empty_i  IN FIFO empty
//   wr_out_fifo_en_o    OUT FIFO write strobe
//   wr_out_fifo_data_o  OUT FIFO write data
//   wr_out_fifo_full_i  OUT FIFO full
//   regs_o              register file, reg n at [8n+7:8n]
//   frame_err_o         one-cycle pulse as each NAK header byte is written
//
// Optional build macro: CMD_TIMEOUT_EN enables the inter-byte timeout
// (NAK 0x05 after TIMEOUT_CYCLES idle cycles mid-frame).
module usb_cmd_decoder #(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned MAX_PAYLOAD    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic                  rd_in_fifo_en_o,
  input  logic [7:0]            rd_in_fifo_data_i,
  input  logic                  rd_in_fifo_empty_i,
  output logic                  wr_out_fifo_en_o,
  output logic [7:0]            wr_out_fifo_data_o,
  input  logic                  wr_out_fifo_full_i,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  frame_err_o
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned BW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [2:0] {
    S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_EXEC, S_RSP
  } state_t;

  state_t      state_q, state_d;
  logic        vld_q;                // IN FIFO data is valid this cycle
  logic [7:0]  cmd_q, len_q, chk_q, cnt_q;
  logic [7:0]  buf_q  [MAX_PAYLOAD];
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  rcmd_q, rlen_q, txchk_q;
  logic [8:0]  ridx_q;
  logic [8:0]  rlast;
  logic [7:0]  rsp_byte;
  logic [BW-1:0] pidx;
  logic [AW-1:0] addr;
  logic        addr_ok;
  logic        rx_state, frame_state;
  logic        err_go, ok_go, reg_wr;
  logic [7:0]  err_code, ok_rlen;
  logic        to_hit;

  assign rx_state    = (state_q == S_HUNT) || (state_q == S_CMD) || (state_q == S_LEN) ||
                       (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign frame_state = rx_state && (state_q != S_HUNT);
  assign addr        = AW'(buf_q[0]);
  assign addr_ok     = 32'(buf_q[0]) < NUM_REGS;
  assign rlast       = {1'b0, rlen_q} + 9'd3;
  assign pidx        = BW'(ridx_q - 9'd3);

`ifdef CMD_TIMEOUT_EN
  logic [31:0] to_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      to_q <= '0;
    end else if (frame_state && !vld_q) begin
      to_q <= to_q + 32'd1;
    end else begin
      to_q <= '0;
    end
  end

  assign to_hit = frame_state && !vld_q && (to_q >= TIMEOUT_CYCLES);
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_HUNT;
    else         state_q <= state_d;
  end

  // Next-state and response-launch decisions
  always_comb begin
    state_d  = state_q;
    err_go   = 1'b0;
    err_code = '0;
    ok_go    = 1'b0;
    ok_rlen  = '0;
    reg_wr   = 1'b0;
    case (state_q)
      S_HUNT: if (vld_q && rd_in_fifo_data_i == 8'hA5) state_d = S_CMD;
      S_CMD: begin
        if (vld_q)       state_d = S_LEN;
        else if (to_hit) begin err_go = 1'b1; err_code = 8'h05; end
      end
      S_LEN: begin
        if (vld_q) begin
          if (32'(rd_in_fifo_data_i) > MAX_PAYLOAD) begin
            err_go = 1'b1; err_code = 8'h03;
          end else if (rd_in_fifo_data_i == 8'h00) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else if (to_hit) begin
          err_go = 1'b1; err_code = 8'h05;
        end
      end
      S_PAYLOAD: begin
        if (vld_q) begin
          if (cnt_q == len_q - 8'd1) state_d = S_CHK;
        end else if (to_hit) begin
          err_go = 1'b1; err_code = 8'h05;
        end
      end
      S_CHK: begin
        if (vld_q) begin
          if (rd_in_fifo_data_i != chk_q) begin err_go = 1'b1; err_code = 8'h01; end
          else                              state_d = S_EXEC;
        end else if (to_hit) begin
          err_go = 1'b1; err_code = 8'h05;
        end
      end
      S_EXEC: begin
        case (cmd_q)
          8'h01: begin ok_go = 1'b1; ok_rlen = len_q; end
          8'h02: begin
            if (len_q != 8'd2)  begin err_go = 1'b1; err_code = 8'h03; end
            else if (!addr_ok)  begin err_go = 1'b1; err_code = 8'h04; end
            else                begin ok_go = 1'b1; reg_wr = 1'b1; end
          end
          8'h03: begin
            if (len_q != 8'd1)  begin err_go = 1'b1; err_code = 8'h03; end
            else if (!addr_ok)  begin err_go = 1'b1; err_code = 8'h04; end
            else                begin ok_go = 1'b1; ok_rlen = 8'd1; end
          end
          default: begin err_go = 1'b1; err_code = 8'h02; end
        endcase
      end
      S_RSP: if (wr_out_fifo_en_o && ridx_q == rlast) state_d = S_HUNT;
      default: state_d = S_HUNT;
    endcase
    if (err_go || ok_go) state_d = S_RSP;
  end

  // Outputs; reset_i gates the strobes so nothing moves during reset
  always_comb begin
    rd_in_fifo_en_o    = !reset_i && rx_state && !rd_in_fifo_empty_i && !vld_q && !to_hit;
    wr_out_fifo_en_o   = !reset_i && (state_q == S_RSP) && !wr_out_fifo_full_i;
    wr_out_fifo_data_o = (!reset_i && state_q == S_RSP) ? rsp_byte : 8'h00;
    frame_err_o        = wr_out_fifo_en_o && (ridx_q == 9'd0) && (rcmd_q == 8'hFF);
  end

  always_comb begin
    if (ridx_q == 9'd0)      rsp_byte = 8'h5A;
    else if (ridx_q == 9'd1) rsp_byte = rcmd_q;
    else if (ridx_q == 9'd2) rsp_byte = rlen_q;
    else if (ridx_q == rlast) rsp_byte = txchk_q;
    else                     rsp_byte = buf_q[pidx];
  end

  // Parser datapath and register file. The response checksum is
  // accumulated over bytes as they leave, so every response kind shares it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q   <= 1'b0;
      cmd_q   <= '0;
      len_q   <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      rcmd_q  <= '0;
      rlen_q  <= '0;
      txchk_q <= '0;
      ridx_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      vld_q <= rd_in_fifo_en_o;
      if (vld_q) begin
        case (state_q)
          S_CMD:     begin cmd_q <= rd_in_fifo_data_i; chk_q <= rd_in_fifo_data_i; end
          S_LEN:     begin len_q <= rd_in_fifo_data_i; chk_q <= chk_q ^ rd_in_fifo_data_i; cnt_q <= '0; end
          S_PAYLOAD: begin chk_q <= chk_q ^ rd_in_fifo_data_i; cnt_q <= cnt_q + 8'd1; end
          default: ;
        endcase
      end
      if (reg_wr) regs_q[addr] <= buf_q[1];
      if (err_go || ok_go) begin
        rcmd_q  <= err_go ? 8'hFF : (cmd_q | 8'h80);
        rlen_q  <= err_go ? 8'h01 : ok_rlen;
        ridx_q  <= '0;
        txchk_q <= '0;
      end else if (wr_out_fifo_en_o) begin
        ridx_q <= ridx_q + 9'd1;
        if (ridx_q != 9'd0 && ridx_q != rlast) txchk_q <= txchk_q ^ rsp_byte;
      end
    end
  end

  // Payload buffer doubles as response payload storage (NAK code, read data)
  always_ff @(posedge clk_i) begin
    if (vld_q && state_q == S_PAYLOAD) buf_q[BW'(cnt_q)] <= rd_in_fifo_data_i;
    if (err_go)                          buf_q[0] <= err_code;
    else if (ok_go && cmd_q == 8'h03)    buf_q[0] <= regs_q[addr];
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[8*i +: 8] = regs_q[i];
  end

endmodule

// File: tb/tb_usb_cmd_decoder.sv
`timescale 1ns/1ps
module tb_usb_cmd_decoder;

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd_en;
  logic [7:0]   rd_data = '0;
  logic         in_empty = 1'b1;
  logic         wr_en;
  logic [7:0]   wr_data;
  logic         out_full = 1'b0;
  logic [127:0] regs;
  logic         ferr;

  logic [7:0] in_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  usb_cmd_decoder #(.NUM_REGS(16), .MAX_PAYLOAD(16), .TIMEOUT_CYCLES(50)) dut (
    .clk_i(clk), .reset_i(reset),
    .rd_in_fifo_en_o(rd_en), .rd_in_fifo_data_i(rd_data), .rd_in_fifo_empty_i(in_empty),
    .wr_out_fifo_en_o(wr_en), .wr_out_fifo_data_o(wr_data), .wr_out_fifo_full_i(out_full),
    .regs_o(regs), .frame_err_o(ferr)
  );

  // IN FIFO model (first-word-after-strobe) and OUT FIFO monitor
  always @(posedge clk) begin
    if (rd_en && in_q.size() > 0) rd_data <= in_q.pop_front();
    in_empty <= (in_q.size() == 0);
    if (wr_en) obs_q.push_back(wr_data);
    if (ferr) err_pulses++;
  end

  task automatic send(input bq_t b);
    @(negedge clk);
    foreach (b[i]) in_q.push_back(b[i]);
  endtask

  task automatic exp_push(input bq_t b);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 3000 && !ok) begin
      @(negedge clk);
      n++;
      if (obs_q.size() >= exp_q.size()) ok = 1'b1;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (wr_en !== 1'b0)  begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    tests++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    tests++; if (regs !== '0)     begin fails++; $display("FAIL reset_regs: got %h want 0", regs); end
    tests++; if (ferr !== 1'b0)   begin fails++; $display("FAIL reset_frame_err: got %b want 0", ferr); end
    tests++; if (rd_en !== 1'b0)  begin fails++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
  endtask

  task automatic test_echo;
    int e0 = err_pulses;
    bit ok;
    logic [7:0] e, a;
    send('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30});
    exp_push('{8'h5A, 8'h81, 8'h02, 8'h11, 8'h22, 8'hB0});
    wait_out(ok);
    tests++; if (!ok) begin fails++; $display("FAIL echo_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      tests++; if (a !== e) begin fails++; $display("FAIL echo_byte: got %h want %h", a, e); end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL echo_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    tests++; if (err_pulses - e0 != 0) begin fails++; $display("FAIL echo_ferr: got %0d want 0", err_pulses - e0); end
  endtask

  task automatic test_write_read;
    bit ok;
    logic [7:0] e, a;
    send('{8'hA5, 8'h02, 8'h02, 8'h03, 8'h5C, 8'h5F});
    exp_push('{8'h5A, 8'h82, 8'h00, 8'h82});
    wait_out(ok);
    tests++; if (!ok) begin fails++; $display("FAIL wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (regs[31:24] !== 8'h5C) begin fails++; $display("FAIL wr_reg3: got %h want 5C", regs[31:24]); end
    tests++; if (regs[23:0] !== 24'h0) begin fails++; $display("FAIL wr_other_regs: got %h want 000000", regs[23:0]); end
    send('{8'hA5, 8'h03, 8'h01, 8'h03, 8'h01});
    exp_push('{8'h5A, 8'h83, 8'h01, 8'h5C, 8'hDE});
    wait_out(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      tests++; if (a !== e) begin fails++; $display("FAIL wr_rd_byte: got %h want %h", a, e); end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL wr_rd_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_errors;
    int e0 = err_pulses;
    bit ok;
    logic [7:0] e, a;
    send('{8'hA5, 8'h01, 8'h01, 8'h77, 8'h00});
    exp_push('{8'h5A, 8'hFF, 8'h01, 8'h01, 8'hFF});
    send('{8'hA5, 8'h03, 8'h01, 8'h20, 8'h22});
    exp_push('{8'h5A, 8'hFF, 8'h01, 8'h04, 8'hFA});
    send('{8'hA5, 8'h01, 8'h11, 8'hA5, 8'h01, 8'h00, 8'h01});
    exp_push('{8'h5A, 8'hFF, 8'h01, 8'h03, 8'hFD, 8'h5A, 8'h81, 8'h00, 8'h81});
    send('{8'hA5, 8'h07, 8'h00, 8'h07});
    exp_push('{8'h5A, 8'hFF, 8'h01, 8'h02, 8'hFC});
    wait_out(ok);
    tests++; if (!ok) begin fails++; $display("FAIL err_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      tests++; if (a !== e) begin fails++; $display("FAIL err_byte: got %h want %h", a, e); end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL err_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    tests++; if (err_pulses - e0 != 4) begin fails++; $display("FAIL err_ferr_pulses: got %0d want 4", err_pulses - e0); end
  endtask

  task automatic test_resync;
    bit ok;
    logic [7:0] e, a;
    send('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01});
    exp_push('{8'h5A, 8'h81, 8'h00, 8'h81});
    wait_out(ok);
    tests++; if (!ok) begin fails++; $display("FAIL resync_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      tests++; if (a !== e) begin fails++; $display("FAIL resync_byte: got %h want %h", a, e); end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL resync_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_pressure;
    bit ok;
    int n = 0;
    int held;
    logic [7:0] e, a;
    send('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30});
    exp_push('{8'h5A, 8'h81, 8'h02, 8'h11, 8'h22, 8'hB0});
    while (obs_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
    tests++; if (obs_q.size() < 2) begin fails++; $display("FAIL bp_start: got %0d bytes want 2", obs_q.size()); end
    out_full = 1'b1;
    held = obs_q.size();
    repeat (20) begin
      @(negedge clk);
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL bp_strobe_while_full: got %b want 0", wr_en); end
    end
    tests++; if (obs_q.size() != held) begin fails++; $display("FAIL bp_held: got %0d bytes want %0d", obs_q.size(), held); end
    out_full = 1'b0;
    wait_out(ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      tests++; if (a !== e) begin fails++; $display("FAIL bp_byte: got %h want %h", a, e); end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL bp_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    logic [7:0] e, a;
    send('{8'hA5, 8'h01});
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (regs !== '0)       begin fails++; $display("FAIL mid_reset_regs: got %h want 0", regs); end
    tests++; if (wr_en !== 1'b0)    begin fails++; $display("FAIL mid_reset_wr_en: got %b want 0", wr_en); end
    tests++; if (wr_data !== 8'h00) begin fails++; $display("FAIL mid_reset_wr_data: got %h want 00", wr_data); end
    tests++; if (ferr !== 1'b0)     begin fails++; $display("FAIL mid_reset_ferr: got %b want 0", ferr); end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL mid_reset_out: got %0d bytes want 0", obs_q.size()); obs_q.delete(); end
    send('{8'hA5, 8'h01, 8'h01, 8'h42, 8'h42});
    exp_push('{8'h5A, 8'h81, 8'h01, 8'h42, 8'hC2});
    wait_out(ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      tests++; if (a !== e) begin fails++; $display("FAIL mid_byte: got %h want %h", a, e); end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL mid_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout;
    int e0 = err_pulses;
    bit ok;
    logic [7:0] e, a;
    send('{8'hA5, 8'h01});
    exp_push('{8'h5A, 8'hFF, 8'h01, 8'h05, 8'hFB});
    wait_out(ok);
    tests++; if (!ok) begin fails++; $display("FAIL to_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      tests++; if (a !== e) begin fails++; $display("FAIL to_byte: got %h want %h", a, e); end
    end
    tests++; if (err_pulses - e0 != 1) begin fails++; $display("FAIL to_ferr: got %0d want 1", err_pulses - e0); end
  endtask
`endif

  initial begin
    test_reset;
    test_echo;
    test_write_read;
    test_errors;
    test_resync;
    test_back_pressure;
    test_reset_midframe;
`ifdef CMD_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
